// File: rtl/regfile_dump_tx_if.sv
// Byte stream from the register dump engine to the debug transmitter.
// The master drives data/valid; the slave answers with ready.
interface regfile_dump_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/regfile_dump_tx.sv
// Debug read-out engine: walks the register file one register per step and
// streams HEADER followed by each register's four bytes, MSB first.
module regfile_dump_tx #(
    parameter logic [4:0] REG_FIRST = 5'd0,
    parameter logic [4:0] REG_LAST  = 5'd31,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [4:0]                 rd_addr,
    input  logic [31:0]                rd_data,
    regfile_dump_tx_if.master          tx
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  addr;
    logic [31:0] shift;
    logic [1:0]  byteCnt;
    logic        busyReg;
    logic        doneReg;
    logic        txValid;
    logic [7:0]  txData;

    // Outputs are registered alongside the state, so tx_data/tx_valid are
    // loaded with the value the next state presents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr    <= 5'd0;
            shift   <= 32'd0;
            byteCnt <= 2'd0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
            txValid <= 1'b0;
            txData  <= 8'd0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= HDR;
                        addr    <= REG_FIRST;
                        busyReg <= 1'b1;
                        txValid <= 1'b1;
                        txData  <= HEADER;
                    end
                end
                HDR: begin
                    if (tx.tx_ready) begin
                        state   <= LOAD;
                        txValid <= 1'b0;
                        txData  <= 8'd0;
                    end
                end
                LOAD: begin
                    // Register is captured here; later writes miss this frame.
                    shift   <= rd_data;
                    byteCnt <= 2'd0;
                    state   <= SEND;
                    txValid <= 1'b1;
                    txData  <= rd_data[31:24];
                end
                SEND: begin
                    if (tx.tx_ready) begin
                        if (byteCnt != 2'd3) begin
                            shift   <= shift << 8;
                            byteCnt <= byteCnt + 2'd1;
                            txData  <= shift[23:16];
                        end else begin
                            txValid <= 1'b0;
                            txData  <= 8'd0;
                            if (addr == REG_LAST) begin
                                state   <= DONE;
                                doneReg <= 1'b1;
                            end else begin
                                addr  <= addr + 5'd1;
                                state <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                    txValid <= 1'b0;
                    txData  <= 8'd0;
                end
            endcase
        end
    end

    assign busy        = busyReg;
    assign done        = doneReg;
    assign rd_addr     = addr;
    assign tx.tx_valid = txValid;
    assign tx.tx_data  = txData;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx: queue-based frame model plus directed scenarios
// (full dump, backpressure, capture boundary, start handling, abort, short variant).
module tb_regfile_dump_tx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic txReady = 1'b1;
    int   rdyMode = 0;

    always #5 clk = ~clk;

    logic [31:0] regs [32];
    logic [4:0]  rdAddr, rdAddr2;
    logic [31:0] rdData, rdData2;
    logic        busy, done, busy2, done2;

    regfile_dump_tx_if tx ();
    regfile_dump_tx_if tx2 ();

    assign rdData  = (rdAddr == 5'd0)  ? 32'd0 : regs[rdAddr];
    assign rdData2 = (rdAddr2 == 5'd0) ? 32'd0 : regs[rdAddr2];
    assign tx.tx_ready  = txReady;
    assign tx2.tx_ready = 1'b1;

    regfile_dump_tx dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_addr(rdAddr), .rd_data(rdData), .tx(tx.master)
    );

    regfile_dump_tx #(.REG_FIRST(5'd8), .REG_LAST(5'd9)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .rd_addr(rdAddr2), .rd_data(rdData2), .tx(tx2.master)
    );

    int nCmp = 0;
    int nFail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: expected byte stream for the main DUT
    logic [7:0] expQ [$];
    bit         monOn = 1'b0;
    int         xferCnt = 0;
    int         doneCnt = 0;
    logic       prevStall = 1'b0;
    logic [7:0] prevData = 8'd0;

    task automatic pushFrame(input int first, input int last);
        logic [31:0] v;
        expQ.push_back(8'hA5);
        for (int r = first; r <= last; r++) begin
            v = (r == 0) ? 32'd0 : regs[r];
            expQ.push_back(v[31:24]);
            expQ.push_back(v[23:16]);
            expQ.push_back(v[15:8]);
            expQ.push_back(v[7:0]);
        end
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            if (tx.tx_valid) begin
                if (prevStall) chk("stall_hold", 32'(tx.tx_data), 32'(prevData));
                if (expQ.size() == 0) begin
                    chk("extra_byte", 32'(tx.tx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("stream_byte", 32'(tx.tx_data), 32'(expQ[0]));
                    if (tx.tx_ready) begin
                        void'(expQ.pop_front());
                        xferCnt++;
                    end
                end
            end else begin
                chk("idle_data", 32'(tx.tx_data), 32'd0);
            end
            prevStall = tx.tx_valid && !tx.tx_ready;
            prevData  = tx.tx_data;
            if (done) doneCnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            txReady = (rdyMode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    int cyc = 0;

    task automatic nextCycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic waitDone(input int bound, output int at);
        at = -1;
        while (at < 0 && cyc < bound) begin
            nextCycle();
            if (done) at = cyc;
        end
        if (at < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_valid"}, 32'(tx.tx_valid), 32'd0);
        chk({tag, "_data"}, 32'(tx.tx_data), 32'd0);
        chk({tag, "_addr"}, 32'(rdAddr), 32'd0);
    endtask

    initial begin
        int d;
        int d0;
        int x0;
        int d2;
        logic [7:0] got [$];
        logic [7:0] exp2 [9];
        exp2 = '{8'hA5, 8'h08, 8'h08, 8'h08, 8'h08, 8'h09, 8'h09, 8'h09, 8'h09};

        for (int i = 0; i < 32; i++) regs[i] = {4{8'(i)}};

        #3;
        chkResetOutputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Full dump with tx_ready held high
        pushFrame(0, 31);
        chk("model_len", 32'(expQ.size()), 32'd129);
        chk("model_hdr", 32'(expQ[0]), 32'hA5);
        chk("model_reg1", 32'(expQ[5]), 32'h01);
        chk("model_last", 32'(expQ[128]), 32'h1F);
        chk("model_reg5", 32'(expQ[21]), 32'h05);
        monOn = 1'b1;
        pulseStart();
        nextCycle();
        chk("hdr_valid", 32'(tx.tx_valid), 32'd1);
        chk("hdr_byte", 32'(tx.tx_data), 32'hA5);
        chk("busy_hdr", 32'(busy), 32'd1);
        waitDone(400, d);
        chk("done_cycle", 32'(d), 32'd162);
        chk("busy_done", 32'(busy), 32'd1);
        nextCycle();
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("frame_len", 32'(expQ.size()), 32'd0);
        chk("rd_addr_hold", 32'(rdAddr), 32'd31);

        // Backpressure at roughly 30% ready
        rdyMode = 1;
        d0 = doneCnt;
        pushFrame(0, 31);
        pulseStart();
        waitDone(5000, d);
        rdyMode = 0;
        repeat (4) nextCycle();
        chk("bp_frame_len", 32'(expQ.size()), 32'd0);
        chk("bp_done_pulses", 32'(doneCnt - d0), 32'd1);

        // Capture boundary: writes land during the SEND of reg 6
        pushFrame(0, 31);
        expQ[41] = 8'hCA; expQ[42] = 8'hFE; expQ[43] = 8'hF0; expQ[44] = 8'h0D;
        pulseStart();
        while (cyc < 34) nextCycle();
        regs[5]  = 32'hDEADBEEF;
        regs[10] = 32'hCAFEF00D;
        waitDone(400, d);
        chk("cap_done_cycle", 32'(d), 32'd162);
        nextCycle();
        chk("cap_frame_len", 32'(expQ.size()), 32'd0);
        regs[5]  = 32'h05050505;
        regs[10] = 32'h0A0A0A0A;

        // Start pulses in HDR and SEND are ignored; held start chains a frame
        pushFrame(0, 31);
        pushFrame(0, 31);
        pulseStart();
        nextCycle();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < 20) nextCycle();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < 100) nextCycle();
        start = 1'b1;
        waitDone(400, d);
        chk("st_done_cycle", 32'(d), 32'd162);
        nextCycle();
        chk("st_idle_busy", 32'(busy), 32'd0);
        chk("st_idle_valid", 32'(tx.tx_valid), 32'd0);
        nextCycle();
        chk("st_second_valid", 32'(tx.tx_valid), 32'd1);
        chk("st_second_hdr", 32'(tx.tx_data), 32'hA5);
        start = 1'b0;
        waitDone(800, d);
        chk("st_second_done", 32'(d), 32'd325);
        nextCycle();
        chk("st_frame_len", 32'(expQ.size()), 32'd0);

        // Abort mid-frame by reset, then a clean frame
        pushFrame(0, 31);
        x0 = xferCnt;
        pulseStart();
        while (xferCnt - x0 < 37 && cyc < 400) nextCycle();
        chk("abort_reached", 32'(xferCnt - x0), 32'd37);
        @(posedge clk);
        #2;
        monOn = 1'b0;
        reset = 1'b0;
        #1;
        chkResetOutputs("abort");
        expQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        prevStall = 1'b0;
        monOn = 1'b1;
        repeat (3) nextCycle();
        chk("abort_no_resume", 32'(tx.tx_valid), 32'd0);
        pushFrame(0, 31);
        pulseStart();
        waitDone(400, d);
        chk("abort_done_cycle", 32'(d), 32'd162);
        nextCycle();
        chk("abort_frame_len", 32'(expQ.size()), 32'd0);

        // Short variant REG_FIRST=8, REG_LAST=9
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        d2 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (tx2.tx_valid && tx2.tx_ready) got.push_back(tx2.tx_data);
            if (done2 && d2 < 0) d2 = c;
        end
        chk("var_done_cycle", 32'(d2), 32'd12);
        chk("var_len", 32'(got.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < got.size()) chk("var_byte", 32'(got[i]), 32'(exp2[i]));
            else chk("var_byte_missing", 32'd0, 32'(exp2[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #400000;
        nFail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $fatal(1, "watchdog expired");
    end

endmodule
